// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register load interface, issues one
// instruction-memory request at a time and fills the IF/ID output registers.
module fetch_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_INC  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_hold,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    typedef enum logic [1:0] {StIdle, StReq, StSquash, StHold} state_e;

    localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(PC_INC);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0]  buf_pc_q, buf_pc_d;
    logic               req_active;
    logic               enter_req;

    assign req_active = (state_q == StReq) || (state_q == StSquash);

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        buf_d         = buf_q;
        buf_pc_d      = buf_pc_q;
        pc_hold       = 1'b1;
        pc_next       = pc_cur + PcInc;
        enter_req     = 1'b0;

        if (redirect && (state_q != StIdle)) begin
            pc_hold       = 1'b0;
            pc_next       = redirect_pc;
            instr_valid_d = 1'b0;
            // A request still waiting for its ack must complete; its data is dropped in StSquash.
            if (req_active && !imem_ack) begin
                state_d = StSquash;
            end else begin
                enter_req = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: enter_req = 1'b1;
                StReq: begin
                    if (imem_ack && !stall) begin
                        pc_hold       = 1'b0;
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_addr_q;
                        instr_valid_d = 1'b1;
                        enter_req     = 1'b1;
                    end else if (imem_ack) begin
                        buf_d    = imem_rdata;
                        buf_pc_d = req_addr_q;
                        state_d  = StHold;
                    end else if (!stall) begin
                        instr_valid_d = 1'b0;
                    end
                end
                StSquash: begin
                    if (imem_ack) begin
                        enter_req = 1'b1;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        pc_hold       = 1'b0;
                        instr_d       = buf_q;
                        instr_pc_d    = buf_pc_q;
                        instr_valid_d = 1'b1;
                        enter_req     = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (enter_req) begin
            state_d    = StReq;
            req_addr_d = pc_hold ? pc_cur : pc_next;
        end

        if (reset) begin
            pc_hold = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            req_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            buf_q         <= '0;
            buf_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            buf_q         <= buf_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

    assign imem_req    = req_active;
    assign imem_addr   = req_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle-exact scenarios plus a randomized run checked
// against a program-order model of the delivered instruction stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    // PC register owned by the surrounding pipeline.
    logic [31:0] pc_q;
    logic [31:0] pc_rst_val;
    always @(posedge clk) begin
        if (reset) pc_q <= pc_rst_val;
        else if (!pc_hold) pc_q <= pc_next;
    end
    assign pc_cur = pc_q;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_W (32),
        .INSTR_W(32),
        .PC_INC (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .pc_hold    (pc_hold),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] rpc);
        imem_ack    = a;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_rdata  = mem_word(imem_addr);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] rv);
        pc_rst_val = rv;
        reset      = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(32'h100);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_pc_hold: got %b want 1", pc_hold); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL rst_instr: got %h/%h want 0/0", instr, instr_pc);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h500);
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL idle_redirect_hold: got %b want 1", pc_hold); end
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL idle_to_req: got req=%b addr=%h want 1/100", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset(32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_idle_req: got %b want 0", imem_req); end
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL zw_addr%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 32'(4 * k));
            end
            checks++; if (pc_hold !== 1'b0 || pc_next !== 32'(4 * k + 4)) begin
                errors++; $display("FAIL zw_pc%0d: got hold=%b next=%h", k, pc_hold, pc_next);
            end
            if (k == 0) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL zw_valid0: got %b want 0", instr_valid); end
            end else begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 1))
                              || instr !== mem_word(32'(4 * (k - 1)))) begin
                    errors++; $display("FAIL zw_out%0d: got v=%b pc=%h i=%h", k, instr_valid, instr_pc, instr);
                end
            end
            cyc();
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc_hold !== 1'b1) begin
                errors++; $display("FAIL ws_wait%0d: got req=%b addr=%h hold=%b", i, imem_req, imem_addr, pc_hold);
            end
            checks++; if (instr_valid !== (i == 0)) begin
                errors++; $display("FAIL ws_valid%0d: got %b want %b", i, instr_valid, i == 0);
            end
            cyc();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h10 || pc_hold !== 1'b0 || pc_next !== 32'h14) begin
            errors++; $display("FAIL ws_ack: got addr=%h hold=%b next=%h", imem_addr, pc_hold, pc_next);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || imem_addr !== 32'h14) begin
            errors++; $display("FAIL ws_out: got v=%b pc=%h addr=%h want 1/10/14", instr_valid, instr_pc, imem_addr);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h20 || pc_hold !== 1'b1) begin
            errors++; $display("FAIL st_ack: got addr=%h hold=%b want 20/1", imem_addr, pc_hold);
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            checks++; if (imem_req !== 1'b0 || pc_hold !== 1'b1 || pc_cur !== 32'h20) begin
                errors++; $display("FAIL st_hold%0d: got req=%b hold=%b pc=%h", i, imem_req, pc_hold, pc_cur);
            end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1C) begin
                errors++; $display("FAIL st_frozen%0d: got v=%b pc=%h want 1/1c", i, instr_valid, instr_pc);
            end
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (pc_hold !== 1'b0 || pc_next !== 32'h24) begin
            errors++; $display("FAIL st_release: got hold=%b next=%h want 0/24", pc_hold, pc_next);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== mem_word(32'h20)) begin
            errors++; $display("FAIL st_out: got v=%b pc=%h i=%h", instr_valid, instr_pc, instr);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
            errors++; $display("FAIL st_next: got req=%b addr=%h want 1/24", imem_req, imem_addr);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
    endtask

    task automatic test_redirect_squash();
        drive(1'b0, 1'b0, 1'b1, 32'h400);
        checks++; if (imem_addr !== 32'h30 || pc_hold !== 1'b0 || pc_next !== 32'h400) begin
            errors++; $display("FAIL sq_redir: got addr=%h hold=%b next=%h", imem_addr, pc_hold, pc_next);
        end
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL sq_wait: got req=%b addr=%h v=%b", imem_req, imem_addr, instr_valid);
        end
        checks++; if (pc_cur !== 32'h400 || pc_hold !== 1'b1) begin
            errors++; $display("FAIL sq_pc: got pc=%h hold=%b want 400/1", pc_cur, pc_hold);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h30 || pc_hold !== 1'b1) begin
            errors++; $display("FAIL sq_ack: got addr=%h hold=%b want 30/1", imem_addr, pc_hold);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL sq_drop: got req=%b addr=%h v=%b", imem_req, imem_addr, instr_valid);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400 || instr !== mem_word(32'h400)) begin
            errors++; $display("FAIL sq_out: got v=%b pc=%h i=%h", instr_valid, instr_pc, instr);
        end
        cyc();
    endtask

    task automatic test_redirect_ack_stall();
        drive(1'b1, 1'b1, 1'b1, 32'h800);
        checks++; if (pc_hold !== 1'b0 || pc_next !== 32'h800 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL ras_redir: got hold=%b next=%h v=%b", pc_hold, pc_next, instr_valid);
        end
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h800 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL ras_nohold: got req=%b addr=%h v=%b", imem_req, imem_addr, instr_valid);
        end
        checks++; if (pc_cur !== 32'h800) begin errors++; $display("FAIL ras_pc: got %h want 800", pc_cur); end
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h800) begin
            errors++; $display("FAIL ras_out: got v=%b pc=%h want 1/800", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_hold !== 1'b0 || pc_next !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got addr=%h hold=%b next=%h", imem_addr, pc_hold, pc_next);
        end
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0 || instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_out: got addr=%h v=%b pc=%h", imem_addr, instr_valid, instr_pc);
        end
    endtask

    // Reference: the consumer must see consecutive addresses from 0, restarting at each
    // redirect target, with instr matching memory contents at instr_pc.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic        pend_prev, redir_prev, mem_new;
        int          wait_left, delivered;
        exp_pc = 32'h0; pend_prev = 1'b0; redir_prev = 1'b0; mem_new = 1'b1;
        wait_left = 0; delivered = 0; pend_addr = 32'h0;
        do_reset(32'h0);
        for (int c = 0; c < 3000; c++) begin
            if (pend_prev) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
                    errors++; $display("FAIL rnd_stable@%0d: got req=%b addr=%h want 1/%h", c, imem_req, imem_addr, pend_addr);
                end
            end
            if (redir_prev) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush@%0d: got v=%b want 0", c, instr_valid); end
            end
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = (c > 0) && ($urandom_range(0, 19) == 0);
            redirect_pc = 32'($urandom_range(0, 1023)) << 2;
            if (imem_req) begin
                if (mem_new) wait_left = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
                imem_ack = (wait_left == 0);
                if (!imem_ack) wait_left--;
                mem_new = imem_ack;
            end else begin
                imem_ack = ($urandom_range(0, 1) == 1);
                mem_new  = 1'b1;
            end
            imem_rdata = mem_word(imem_addr);
            #1;
            if (redirect) begin
                checks++; if (pc_hold !== 1'b0 || pc_next !== redirect_pc) begin
                    errors++; $display("FAIL rnd_redir@%0d: got hold=%b next=%h want 0/%h", c, pc_hold, pc_next, redirect_pc);
                end
                exp_pc = redirect_pc;
            end else begin
                if (imem_req && !imem_ack) begin
                    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rnd_hold@%0d: got %b want 1", c, pc_hold); end
                end else if (!pc_hold) begin
                    checks++; if (pc_next !== pc_cur + 32'd4) begin
                        errors++; $display("FAIL rnd_next@%0d: got %h want %h", c, pc_next, pc_cur + 32'd4);
                    end
                end
                if (instr_valid && !stall) begin
                    checks++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                        errors++; $display("FAIL rnd_stream@%0d: got pc=%h i=%h want pc=%h i=%h", c, instr_pc, instr, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end
            pend_prev  = imem_req && !imem_ack;
            pend_addr  = imem_addr;
            redir_prev = redirect;
            cyc();
        end
        checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d want >=200", delivered); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_hold !== 1'b1) begin
            errors++; $display("FAIL mid_rst: got req=%b v=%b hold=%b", imem_req, instr_valid, pc_hold);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_stray: got req=%b addr=%h v=%b", imem_req, imem_addr, instr_valid);
        end
    endtask

    initial begin
        reset = 1'b1; pc_rst_val = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_squash();
        test_redirect_ack_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that drives the PC register's load interface. It receives the registered PC value, issues instruction-memory requests, and writes the next PC back as pc_next plus an active-high hold. It also fills the IF/ID instruction output. It handles variable-latency memory acks, downstream stalls, and branch/jump redirects, including squashing fetches that are already in flight.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address.
INSTR_W, 32, instruction width.
PC_INC, 4, byte increment for sequential fetch.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high.
pc_cur  input  ADDR_W  current PC register value.
pc_next  output  ADDR_W  value the PC register loads when pc_hold=0 (combinational).
pc_hold  output  1  1 = PC register keeps value, 0 = PC register loads pc_next (combinational).
imem_req  output  1  fetch request; held high with imem_addr stable until imem_ack.
imem_addr  output  ADDR_W  fetch address (registered req_addr).
imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1.
imem_rdata  input  INSTR_W  fetched instruction.
stall  input  1  IF/ID cannot accept; output registers hold.
redirect  input  1  branch/jump taken; single-cycle pulse.
redirect_pc  input  ADDR_W  redirect target.
instr_valid  output  1  IF/ID contents valid.
instr  output  INSTR_W  fetched instruction.
instr_pc  output  ADDR_W  address of instr.

Behaviour:
- Reset: state=IDLE, imem_req=0, req_addr=0, instr_valid=0, instr=0, instr_pc=0, buffer cleared; pc_hold=1 while reset=1. Reset mid-request abandons the request; a later stray ack is ignored because imem_req=0.
- States: IDLE, REQ, SQUASH, HOLD. imem_req=1 in REQ and SQUASH only.
- Default combinational outputs: pc_hold=1, pc_next=pc_cur+PC_INC, computed modulo 2^ADDR_W (0xFFFFFFFC+4 wraps to 0x00000000).
- On every entry to REQ: req_addr <= (pc_hold ? pc_cur : pc_next).
- IDLE -> REQ unconditionally after one cycle.
- REQ, imem_ack=1, stall=0:
  - pc_hold=0.
  - instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1.
  - Stay in REQ with the new address.
  - Latency: instr_valid rises 1 cycle after ack.
  - Zero-wait memory sustains 1 instruction per cycle.
- REQ, imem_ack=1, stall=1: buffer<=imem_rdata, buf_pc<=req_addr; output registers hold; pc_hold=1; -> HOLD.
- REQ, imem_ack=0: pc_hold=1. If stall=0, instr_valid<=0 (bubble); if stall=1, outputs hold.
- HOLD, stall=0: outputs load from buffer with instr_valid<=1; pc_hold=0; -> REQ. HOLD, stall=1: remain in HOLD.
- SQUASH: keep imem_req=1 and req_addr unchanged until ack. Discard the ack data, then -> REQ with req_addr<=pc_cur (the already-redirected PC).
- Redirect has highest priority and overrides stall in every state except IDLE:
  - pc_hold=0, pc_next=redirect_pc, instr_valid<=0.
  - In REQ without ack in the same cycle: -> SQUASH.
  - In REQ with ack in the same cycle: data dropped, -> REQ at redirect_pc.
  - In HOLD: buffer dropped, -> REQ at redirect_pc.
  - In SQUASH: stay in SQUASH; the PC is updated again, and the outstanding ack is still discarded.
  - Redirect during IDLE is ignored.
- At most one request is outstanding at any time. imem_addr never changes while imem_req=1 and ack has not yet arrived.

Test Plan:
- Reset, zero-wait memory (ack same cycle as req), no stall, PC starts at 0 -> imem_addr 0,4,8,C on consecutive cycles; instr_valid high from the 3rd cycle after reset release; instr_pc follows 1 cycle behind imem_addr.
- Memory with a 3-cycle ack delay at address 0x10 -> imem_addr held at 0x10 for 3 cycles; pc_hold=1 throughout; instr_valid=0 bubbles; one valid instr with instr_pc=0x10, then imem_addr=0x14.
- Ack at 0x20 with stall=1 for 2 cycles -> instr/instr_valid frozen, PC held at 0x20, no new imem_req; after stall drops, instr_pc=0x20 presented and imem_addr=0x24.
- Redirect to 0x400 while the 0x30 request is waiting (2 cycles) -> imem_addr stays 0x30 until ack, data discarded (instr_valid=0), then imem_addr=0x400 and first valid instr_pc=0x400.
- Redirect coincident with ack and stall=1 -> redirect wins: PC loads redirect_pc, data dropped, instr_valid=0, no HOLD entry.
- pc_cur=0xFFFFFFFC with ack -> pc_next=0x00000000; next imem_addr=0x0.
